instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction/immediate width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, byte-address width of the instruction-memory write port.
REQ-003 SHALL have parameter BASE_ADDR, default 0, word-aligned first write address after reset/flush.
REQ-004 SHALL have ports: clk  in  1  clock; single clock domain, rising edge.
REQ-005 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have ports: flush  in  1  drop buffered words and reload address to BASE_ADDR.
REQ-007 SHALL have ports: in_valid  in  1 / in_ready  out  1  request handshake.
REQ-008 SHALL have ports: in_opcode  in  7, in_rd  in  5, in_rs1  in  5, in_rs2  in  5, in_funct3  in  3, in_funct7  in  7.
REQ-009 SHALL have ports: in_imm  in  DATA_WIDTH  signed immediate (U-type: full value, low 12 bits zero).
REQ-010 SHALL have ports: out_valid  out  1 / out_ready  in  1  write handshake.
REQ-011 SHALL have ports: out_addr  out  ADDR_WIDTH, out_instr  out  DATA_WIDTH  encoded word.
REQ-012 SHALL have ports: err  out  1  one-cycle error pulse; err_count  out  8  saturating error count.

Function
REQ-013 SHALL encode by opcode: 0010011 I-type {imm[11:0],rs1,funct3,rd,op}; 0100011 S-type {imm[11:5],rs2,rs1,funct3,imm[4:0],op}; 0010111 U-type {imm[31:12],rd,op}; 0110011 R-type {funct7,rs2,rs1,funct3,rd,op}.
REQ-014 SHALL accept a request on a clk edge where in_valid && in_ready && !flush.
REQ-015 SHALL hold encoded words in a 2-entry FIFO; in_ready = !full && !flush.
REQ-016 SHALL present an accepted word at out_valid the cycle after acceptance (latency 1), FIFO order.
REQ-017 SHALL pop the head on out_valid && out_ready; simultaneous push and pop on a full FIFO is not permitted (in_ready low when full).
REQ-018 SHALL assign out_addr from an address counter at acceptance; counter increments by 4, wraps modulo 2^ADDR_WIDTH.
REQ-019 SHALL treat an unsupported opcode as an error: request consumed, nothing pushed, address not advanced, err pulsed next cycle, err_count += 1 saturating at 255.
REQ-020 SHALL on flush empty the FIFO, set address to BASE_ADDR, deassert out_valid next cycle; flush beats any simultaneous push/pop; err_count is kept.
REQ-021 SHALL never change out_addr/out_instr while out_valid && !out_ready.

Reset
REQ-022 SHALL on rst: FIFO empty, out_valid=0, out_addr=BASE_ADDR, out_instr=0, err=0, err_count=0, address=BASE_ADDR; in_ready=0 while rst high.
REQ-023 SHALL let rst override flush and all handshakes, including mid-transfer.

Configuration
REQ-024 SHALL honour macro INSTR_ENC_IMM_CHECK_EN.
REQ-025 SHALL with macro defined: flag as error (REQ-019 handling) I/S imm outside [-2048,2047] and U imm with imm[11:0]!=0.
REQ-026 SHALL without macro: silently truncate immediates to field bits, no range errors.

Structure
REQ-027 SHALL place opcode constants (OP_IMM, OP_STORE, OP_AUIPC, OP_REG) and a format enum in shared package riscv_pkg.
REQ-028 SHALL implement field packing in combinational sub-module instr_field_packer (opcode+fields -> word, fmt_valid, imm_ok).

Verification
REQ-029 SHALL test: op=0010011 rd=1 rs1=0 f3=0 imm=5 -> out_instr=0x00500093, out_addr=BASE_ADDR, one cycle after accept.
REQ-030 SHALL test: op=0100011 rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423; op=0010111 rd=5 imm=0x12345000 -> 0x12345297, addresses +4 each.
REQ-031 SHALL test: out_ready=0, three back-to-back requests -> two buffered, in_ready=0 on third, outputs stable; release -> FIFO order.
REQ-032 SHALL test: opcode 1111111 -> err pulse, err_count=1, no out_valid, next valid word gets unchanged address.
REQ-033 SHALL test: with macro, I imm=2048 -> error; without, -> encoded imm field 0x800; flush with in_valid high -> not accepted, next address BASE_ADDR.
REQ-034 SHALL test: ADDR_WIDTH=4, 5 words -> addresses 0,4,8,12,0 (wrap).

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants and instruction-format decode for the encoder slice.
package riscv_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_U,
        FMT_R,
        FMT_NONE
    } fmt_e;

    function automatic fmt_e decode_fmt(input logic [6:0] opcode);
        case (opcode)
            OP_IMM:   return FMT_I;
            OP_STORE: return FMT_S;
            OP_AUIPC: return FMT_U;
            OP_REG:   return FMT_R;
            default:  return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational field packer: opcode + register/immediate fields -> 32-bit instruction word.
// DATA_WIDTH must be at least 32; wider words are zero-extended.
module instr_field_packer
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  fmt_valid,
    output logic                  imm_ok
);

    fmt_e        fmt;
    logic [31:0] enc;
    logic        imm_fits_12;

    assign fmt = decode_fmt(opcode);

    // Fits a signed 12-bit field when every bit from 11 upward is a copy of the sign.
    assign imm_fits_12 = (&imm[DATA_WIDTH-1:11]) || !(|imm[DATA_WIDTH-1:11]);

    always_comb begin
        enc       = '0;
        fmt_valid = 1'b1;
        imm_ok    = 1'b1;
        case (fmt)
            FMT_I: begin
                enc    = {imm[11:0], rs1, funct3, rd, opcode};
                imm_ok = imm_fits_12;
            end
            FMT_S: begin
                enc    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                imm_ok = imm_fits_12;
            end
            FMT_U: begin
                enc    = {imm[31:12], rd, opcode};
                imm_ok = (imm[11:0] == 12'd0);
            end
            FMT_R: begin
                enc = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            default: begin
                fmt_valid = 1'b0;
            end
        endcase
    end

    assign word = DATA_WIDTH'(enc);

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs requests into words and writes them, with addresses, through a 2-entry FIFO.
// Optional macro INSTR_ENC_IMM_CHECK_EN turns out-of-range immediates into errors instead of truncating.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic                  err,
    output logic [7:0]            err_count
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
    // waits on ready, and the presented payload holds steady until that edge.
    logic [DATA_WIDTH-1:0] enc_word;
    logic                  fmt_valid;
    logic                  imm_ok;
    logic                  req_ok;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  err_now;

    logic [DATA_WIDTH-1:0] mem_instr [2];
    logic [ADDR_WIDTH-1:0] mem_addr  [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic [ADDR_WIDTH-1:0] addr_q;

    instr_field_packer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_packer (
        .opcode    (in_opcode),
        .rd        (in_rd),
        .rs1       (in_rs1),
        .rs2       (in_rs2),
        .funct3    (in_funct3),
        .funct7    (in_funct7),
        .imm       (in_imm),
        .word      (enc_word),
        .fmt_valid (fmt_valid),
        .imm_ok    (imm_ok)
    );

`ifdef INSTR_ENC_IMM_CHECK_EN
    assign req_ok = fmt_valid && imm_ok;
`else
    logic unused_imm_ok;
    assign unused_imm_ok = imm_ok;
    assign req_ok        = fmt_valid;
`endif

    assign in_ready  = !rst && !flush && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_instr = mem_instr[rd_ptr];
    assign out_addr  = mem_addr[rd_ptr];

    // A rejected request is still consumed; it only skips the push and the address bump.
    assign accept  = in_valid && in_ready;
    assign push    = accept && req_ok;
    assign err_now = accept && !req_ok;
    assign pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            addr_q    <= BASE;
            err       <= 1'b0;
            err_count <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                mem_instr[i] <= '0;
                mem_addr[i]  <= BASE;
            end
        end else begin
            err <= err_now;
            if (err_now && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (flush) begin
                count  <= 2'd0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                addr_q <= BASE;
            end else begin
                if (push) begin
                    mem_instr[wr_ptr] <= enc_word;
                    mem_addr[wr_ptr]  <= addr_q;
                    wr_ptr            <= ~wr_ptr;
                    addr_q            <= addr_q + STEP;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: queue-based reference model checked every cycle plus literal vectors.
module tb_instr_encoder;
    import riscv_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int BASE = 64;
    localparam int W    = AW + DW;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_opcode;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [DW-1:0] in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_instr;
    logic          err;
    logic [7:0]    err_count;

    // Small-address instance for the wrap check
    logic          w_rst;
    logic          w_in_valid;
    logic          w_in_ready;
    logic [4:0]    w_in_rd;
    logic [DW-1:0] w_in_imm;
    logic          w_out_valid;
    logic          w_out_ready;
    logic [3:0]    w_out_addr;
    logic [DW-1:0] w_out_instr;
    logic          w_err;
    logic [7:0]    w_err_count;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    instr_encoder #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_instr (out_instr),
        .err       (err),
        .err_count (err_count)
    );

    instr_encoder #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(4),
        .BASE_ADDR (0)
    ) dut_w (
        .clk       (clk),
        .rst       (w_rst),
        .flush     (1'b0),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_opcode (OP_IMM),
        .in_rd     (w_in_rd),
        .in_rs1    (5'd0),
        .in_rs2    (5'd0),
        .in_funct3 (3'd0),
        .in_funct7 (7'd0),
        .in_imm    (w_in_imm),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_addr  (w_out_addr),
        .out_instr (w_out_instr),
        .err       (w_err),
        .err_count (w_err_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [31:0] imm);
        case (op)
            7'b0010011: return {imm[11:0], rs1, f3, rd, op};
            7'b0100011: return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            7'b0010111: return {imm[31:12], rd, op};
            7'b0110011: return {f7, rs2, rs1, f3, rd, op};
            default:    return 32'd0;
        endcase
    endfunction

    function automatic bit ref_ok(input logic [6:0] op, input logic [31:0] imm);
        bit supported;
        supported = (op == 7'b0010011) || (op == 7'b0100011) ||
                    (op == 7'b0010111) || (op == 7'b0110011);
`ifdef INSTR_ENC_IMM_CHECK_EN
        begin
            int v;
            v = $signed(imm);
            if ((op == 7'b0010011 || op == 7'b0100011) && (v < -2048 || v > 2047)) supported = 0;
            if (op == 7'b0010111 && imm[11:0] != 12'd0) supported = 0;
        end
`endif
        return supported;
    endfunction

    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] exp_addr;
    bit            exp_err;
    int            exp_cnt;
    bit            model_live = 0;

    always @(posedge clk) begin
        model_live = 1;
        if (rst) begin
            exp_q.delete();
            exp_addr = AW'(BASE);
            exp_err  = 0;
            exp_cnt  = 0;
        end else begin
            bit acc;
            acc     = in_valid && !flush && (exp_q.size() < 2);
            exp_err = 0;
            if (flush) begin
                exp_q.delete();
                exp_addr = AW'(BASE);
            end else begin
                if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
                if (acc) begin
                    if (ref_ok(in_opcode, in_imm)) begin
                        exp_q.push_back({exp_addr, ref_encode(in_opcode, in_rd, in_rs1, in_rs2,
                                                              in_funct3, in_funct7, in_imm)});
                        exp_addr = exp_addr + AW'(4);
                    end else begin
                        exp_err = 1;
                        if (exp_cnt < 255) exp_cnt++;
                    end
                end
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        if (model_live) begin
            logic [W-1:0] head;
            check("m_in_ready", {63'd0, in_ready}, {63'd0, !rst && !flush && (exp_q.size() < 2)});
            check("m_out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                check("m_out_instr", 64'(out_instr), 64'(head[DW-1:0]));
                check("m_out_addr", 64'(out_addr), 64'(head[W-1:DW]));
            end
            check("m_err", {63'd0, err}, {63'd0, exp_err});
            check("m_err_count", 64'(err_count), 64'(exp_cnt));
        end
    end

    // ---------------- drivers ----------------
    bit rand_ready = 0;
    always @(posedge clk) begin
        if (rand_ready) begin
            #2;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
    endtask

    task automatic wait_accept(input string name);
        int n;
        bit got;
        n   = 0;
        got = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #2;
            n++;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s: request not accepted within 50 cycles", name);
        end
    endtask

    task automatic send(input string name, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        drive(op, rd, rs1, rs2, f3, f7, imm);
        wait_accept(name);
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [6:0]  mix_op  [6];
    logic [31:0] mix_imm [6];
    int          wrap_exp[5];

    initial begin
        mix_op   = '{OP_IMM, OP_STORE, OP_AUIPC, OP_REG, 7'h03, OP_IMM};
        mix_imm  = '{32'hFFFF_F800, 32'd2047, 32'hABCD_E000, 32'd0, 32'd1, 32'd100};
        wrap_exp = '{0, 4, 8, 12, 0};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        w_rst = 1'b1; w_in_valid = 1'b0; w_in_rd = 5'd0; w_in_imm = '0; w_out_ready = 1'b1;
        step(3);

        // Reset state, with a request pending
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'(BASE));
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        step(1);
        in_valid = 1'b0; rst = 1'b0; w_rst = 1'b0;
        step(1);

        // Basic formats, one cycle after acceptance
        send("i_type", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        check("i_valid", {63'd0, out_valid}, 64'd1);
        check("i_instr", 64'(out_instr), 64'h0050_0093);
        check("i_addr", 64'(out_addr), 64'(BASE));
        step(0); pop_one();

        send("s_type", OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        @(negedge clk);
        check("s_instr", 64'(out_instr), 64'h0020_A423);
        check("s_addr", 64'(out_addr), 64'(BASE + 4));
        pop_one();

        send("u_type", OP_AUIPC, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        @(negedge clk);
        check("u_instr", 64'(out_instr), 64'h1234_5297);
        check("u_addr", 64'(out_addr), 64'(BASE + 8));
        pop_one();

        send("r_type", OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
        @(negedge clk);
        check("r_instr", 64'(out_instr), 64'h4020_81B3);
        check("r_addr", 64'(out_addr), 64'(BASE + 12));
        pop_one();

        // Backpressure: two buffered, third stalls, head holds steady
        send("bp_a", OP_IMM, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        send("bp_b", OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        drive(OP_REG, 5'd4, 5'd2, 5'd3, 3'd7, 7'd0, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_hold_instr", 64'(out_instr), 64'hFFF0_8113);
            check("bp_hold_addr", 64'(out_addr), 64'(BASE + 16));
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        wait_accept("bp_c");
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_c_instr", 64'(out_instr), 64'h0031_7233);
        check("bp_c_addr", 64'(out_addr), 64'(BASE + 24));
        step(1);
        out_ready = 1'b0;

        // Unsupported opcode
        send("bad_op", 7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        @(negedge clk);
        check("bad_err", {63'd0, err}, 64'd1);
        check("bad_err_count", 64'(err_count), 64'd1);
        check("bad_no_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #2;
        @(negedge clk);
        check("bad_err_pulse", {63'd0, err}, 64'd0);
        step(1);
        send("after_bad", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        check("after_bad_addr", 64'(out_addr), 64'(BASE + 28));
        pop_one();

        // Immediate one past the signed 12-bit range
        send("imm_2048", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        @(negedge clk);
`ifdef INSTR_ENC_IMM_CHECK_EN
        check("imm_2048_err", {63'd0, err}, 64'd1);
        check("imm_2048_count", 64'(err_count), 64'd2);
`else
        check("imm_2048_instr", 64'(out_instr), 64'h8000_0093);
        check("imm_2048_addr", 64'(out_addr), 64'(BASE + 32));
`endif
        pop_one();

        // Flush with a request pending
        send("pre_flush", OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        drive(OP_IMM, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #2;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        step(1);
        send("post_flush", OP_IMM, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        @(negedge clk);
        check("post_flush_instr", 64'(out_instr), 64'h0030_0393);
        check("post_flush_addr", 64'(out_addr), 64'(BASE));
        pop_one();

        // Mixed stream under random backpressure
        rand_ready = 1;
        for (int i = 0; i < 18; i++) begin
            send("mix", mix_op[i % 6], 5'(i), 5'(i + 1), 5'(i + 2), 3'(i), 7'(i * 3), mix_imm[i % 6] + 32'(i));
        end
        rand_ready = 0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        step(3);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            send("sat", 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        end
        @(negedge clk);
        check("err_sat", 64'(err_count), 64'd255);
        step(1);

        // Reset in the middle of traffic
        out_ready = 1'b0;
        send("pre_rst_a", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        send("pre_rst_b", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        drive(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        flush = 1'b1; out_ready = 1'b1; rst = 1'b1;
        step(1);
        @(negedge clk);
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_count", 64'(err_count), 64'd0);
        check("mid_rst_addr", 64'(out_addr), 64'(BASE));
        check("mid_rst_instr", 64'(out_instr), 64'd0);
        step(1);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step(1);
        send("post_rst", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        check("post_rst_addr", 64'(out_addr), 64'(BASE));
        pop_one();

        // Address wrap on the 4-bit instance
        for (int i = 0; i < 5; i++) begin
            int  n;
            bit  got;
            w_in_rd    = 5'(i + 1);
            w_in_imm   = 32'(i);
            w_in_valid = 1'b1;
            n = 0; got = 0;
            while (!got && n < 20) begin
                @(negedge clk);
                got = w_in_ready;
                @(posedge clk); #2;
                n++;
            end
            w_in_valid = 1'b0;
            check("wrap_accept", {63'd0, got}, 64'd1);
            @(negedge clk);
            check("wrap_valid", {63'd0, w_out_valid}, 64'd1);
            check("wrap_addr", 64'(w_out_addr), 64'(wrap_exp[i]));
            check("wrap_instr", 64'(w_out_instr),
                  64'(ref_encode(OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i))));
            @(posedge clk); #2;
        end
        check("wrap_err", 64'(w_err_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
